// File: rtl/pool_flatten_buffer_pkg.sv
// rtl/pool_flatten_buffer_pkg.sv - shared constants and types for the pool flatten buffer
package pool_flatten_buffer_pkg;

  localparam int N_CH   = 4;
  localparam int W_DEF  = 26;
  localparam int POOL_W = W_DEF / 2;
  localparam int OUT_N  = POOL_W * POOL_W;
  localparam int IDX_W  = $clog2(OUT_N);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Entries per channel for a conv map of width w (pooled map is w/2 square).
  function automatic int map_n(input int w);
    return (w / 2) * (w / 2);
  endfunction

endpackage

// File: rtl/pool_flatten_buffer_chan_buf.sv
// rtl/pool_flatten_buffer_chan_buf.sv - one channel's map storage with saturating write pointer
module pool_flatten_buffer_chan_buf #(
  parameter int DW    = 32,
  parameter int DEPTH = 169,
  parameter int AW    = $clog2(DEPTH),
  parameter int PW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 wr_en,
  input  logic signed [DW-1:0] wr_data,
  input  logic                 clr,
  input  logic [AW-1:0]        rd_idx,
  output logic signed [DW-1:0] rd_data,
  output logic                 full
);

  logic signed [DW-1:0] mem [DEPTH];
  logic [PW-1:0]        wptr;
  logic                 wr_do;

  assign full    = (wptr == PW'(DEPTH));
  assign wr_do   = wr_en && !full;
  assign rd_data = mem[rd_idx];

  // Write pointer: saturates at DEPTH, cleared when the frame has been drained.
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      wptr <= '0;
    end else if (wr_do) begin
      wptr <= wptr + 1'b1;
    end
  end

  // Sample storage; contents need no reset because the pointer gates visibility.
  always_ff @(posedge clk) begin
    if (wr_do) begin
      mem[wptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/pool_flatten_buffer.sv
// rtl/pool_flatten_buffer.sv - gathers four pooled maps and streams them channel-major
module pool_flatten_buffer
  import pool_flatten_buffer_pkg::*;
#(
  parameter int In_d_W = 32,
  parameter int W      = W_DEF,
  localparam int MAP_N  = map_n(W),
  localparam int ADDR_W = $clog2(MAP_N)
) (
  input  logic                     iClk,
  input  logic                     iRsn,
  input  logic [N_CH-1:0]          iValid4,
  input  logic signed [In_d_W-1:0] iData0,
  input  logic signed [In_d_W-1:0] iData1,
  input  logic signed [In_d_W-1:0] iData2,
  input  logic signed [In_d_W-1:0] iData3,
  output logic                     oValid,
  input  logic                     iReady,
  output logic signed [In_d_W-1:0] oData,
  output logic [1:0]               oChan,
  output logic [ADDR_W-1:0]        oIdx,
  output logic                     oLast,
  output logic                     oBusy,
  output logic                     oOvf
);

  state_t                   state, next_state;
  logic [N_CH-1:0]          full;
  logic [N_CH-1:0]          drop;
  logic signed [In_d_W-1:0] wr_data [N_CH];
  logic signed [In_d_W-1:0] rd_data [N_CH];
  logic                     beat, last_beat, enter, clr;
  logic [1:0]               nxt_ch;
  logic [ADDR_W-1:0]        nxt_idx;

  assign wr_data[0] = iData0;
  assign wr_data[1] = iData1;
  assign wr_data[2] = iData2;
  assign wr_data[3] = iData3;

  assign beat      = oValid && iReady;
  assign last_beat = beat && oLast;
  assign oBusy     = (state == DRAIN);

  // Anything arriving while draining, or for a channel that is already full, is lost.
  assign drop = (state == DRAIN) ? iValid4 : (iValid4 & full);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    pool_flatten_buffer_chan_buf #(
      .DW    (In_d_W),
      .DEPTH (MAP_N)
    ) u_buf (
      .clk     (iClk),
      .resetn  (iRsn),
      .wr_en   (iValid4[c] && (state == FILL)),
      .wr_data (wr_data[c]),
      .clr     (clr),
      .rd_idx  (nxt_idx),
      .rd_data (rd_data[c]),
      .full    (full[c])
    );
  end

  // State register.
  always_ff @(posedge iClk) begin
    if (!iRsn) begin
      state <= FILL;
    end else begin
      state <= next_state;
    end
  end

  // Next state, frame start/end strobes and the address of the element loaded next.
  always_comb begin
    next_state = state;
    enter      = 1'b0;
    clr        = 1'b0;
    unique case (state)
      FILL: begin
        if (&full) begin
          next_state = DRAIN;
          enter      = 1'b1;
        end
      end
      DRAIN: begin
        if (last_beat) begin
          next_state = FILL;
          clr        = 1'b1;
        end
      end
      default: next_state = FILL;
    endcase

    nxt_ch  = oChan;
    nxt_idx = oIdx;
    if (enter) begin
      nxt_ch  = '0;
      nxt_idx = '0;
    end else if (oIdx == ADDR_W'(MAP_N - 1)) begin
      nxt_ch  = oChan + 2'd1;
      nxt_idx = '0;
    end else begin
      nxt_idx = oIdx + 1'b1;
    end
  end

  // Output register: loads element (0,0) on entry, advances on each accepted beat, holds when stalled.
  always_ff @(posedge iClk) begin
    if (!iRsn) begin
      oValid <= 1'b0;
      oData  <= '0;
      oChan  <= '0;
      oIdx   <= '0;
      oLast  <= 1'b0;
    end else if (enter) begin
      oValid <= 1'b1;
      oData  <= rd_data[nxt_ch];
      oChan  <= '0;
      oIdx   <= '0;
      oLast  <= 1'b0;
    end else if (last_beat) begin
      oValid <= 1'b0;
      oData  <= '0;
      oChan  <= '0;
      oIdx   <= '0;
      oLast  <= 1'b0;
    end else if (beat) begin
      oData  <= rd_data[nxt_ch];
      oChan  <= nxt_ch;
      oIdx   <= nxt_idx;
      oLast  <= (nxt_ch == 2'(N_CH - 1)) && (nxt_idx == ADDR_W'(MAP_N - 1));
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge iClk) begin
    if (!iRsn) begin
      oOvf <= 1'b0;
    end else if (|drop) begin
      oOvf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pool_flatten_buffer.sv
// tb/tb_pool_flatten_buffer.sv - scoreboard bench for pool_flatten_buffer
module tb_pool_flatten_buffer;

  localparam int DW = 32;
  localparam int N  = 169;

  logic                 clk = 1'b0;
  logic                 rsn;
  logic [3:0]           valid4;
  logic signed [DW-1:0] d0, d1, d2, d3;
  logic                 o_valid, ready;
  logic signed [DW-1:0] o_data;
  logic [1:0]           o_chan;
  logic [7:0]           o_idx;
  logic                 o_last, o_busy, o_ovf;

  always #5 clk = ~clk;

  pool_flatten_buffer #(.In_d_W(DW), .W(26)) dut (
    .iClk    (clk),
    .iRsn    (rsn),
    .iValid4 (valid4),
    .iData0  (d0),
    .iData1  (d1),
    .iData2  (d2),
    .iData3  (d3),
    .oValid  (o_valid),
    .iReady  (ready),
    .oData   (o_data),
    .oChan   (o_chan),
    .oIdx    (o_idx),
    .oLast   (o_last),
    .oBusy   (o_busy),
    .oOvf    (o_ovf)
  );

  typedef struct {
    logic [31:0] d;
    logic [1:0]  c;
    logic [7:0]  i;
    logic        l;
  } beat_t;

  beat_t sb[$];
  beat_t wr[$];
  int checks = 0;
  int errors = 0;

  // Record one stored sample (in write order); build_sb reorders channel-major.
  task automatic note_write(input int c, input logic [31:0] v);
    beat_t b;
    b.d = v; b.c = 2'(c); b.i = 8'd0; b.l = 1'b0;
    wr.push_back(b);
  endtask

  task automatic build_sb();
    beat_t b;
    int k;
    for (int c = 0; c < 4; c++) begin
      k = 0;
      foreach (wr[j]) begin
        if (wr[j].c == 2'(c)) begin
          b   = wr[j];
          b.i = 8'(k);
          b.l = (c == 3) && (k == N - 1);
          sb.push_back(b);
          k++;
        end
      end
    end
    wr.delete();
  endtask

  task automatic set_in(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] e);
    valid4 = v; d0 = a; d1 = b; d2 = c; d3 = e;
  endtask

  task automatic check_no_valid(input string name);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: oValid=%b required 0", name, o_valid);
    end
  endtask

  // Streams the scoreboard out; ready_pct sets iReady probability, stop_after limits beats,
  // inj_at injects one all-channel input (0xBEEF) during DRAIN at that beat count (-1 = none).
  task automatic drain(input int ready_pct, input int stop_after, input int inj_at);
    int    nbeats = 0;
    int    cyc = 0;
    bit    stalled = 0;
    bit    injected = 0;
    beat_t held;
    beat_t exp_b;
    while (sb.size() > 0 && nbeats < stop_after && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (inj_at >= 0 && nbeats == inj_at && !injected) begin
        set_in(4'hF, 32'hBEEF, 32'hBEEF, 32'hBEEF, 32'hBEEF);
        injected = 1;
      end else begin
        set_in(4'h0, 0, 0, 0, 0);
      end
      checks++;
      if (o_valid !== 1'b1 || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL drain_valid: oValid=%b oBusy=%b required 1 1 at beat %0d", o_valid, o_busy, nbeats);
        ready = 1'b0;
        return;
      end
      if (stalled) begin
        checks++;
        if (o_data !== held.d || o_chan !== held.c || o_idx !== held.i || o_last !== held.l) begin
          errors++;
          $display("FAIL stall_hold: got %h/%0d/%0d/%b required %h/%0d/%0d/%b",
                   o_data, o_chan, o_idx, o_last, held.d, held.c, held.i, held.l);
        end
      end
      exp_b = sb[0];
      checks++;
      if (o_data !== exp_b.d || o_chan !== exp_b.c || o_idx !== exp_b.i || o_last !== exp_b.l) begin
        errors++;
        $display("FAIL beat %0d: got %h/%0d/%0d/%b required %h/%0d/%0d/%b", nbeats,
                 o_data, o_chan, o_idx, o_last, exp_b.d, exp_b.c, exp_b.i, exp_b.l);
      end
      ready = ($urandom_range(99) < ready_pct);
      if (ready) begin
        void'(sb.pop_front());
        nbeats++;
        stalled = 0;
      end else begin
        stalled = 1;
        held = exp_b;
      end
    end
    if (cyc >= 5000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: beats %0d required %0d", nbeats, stop_after);
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    ready = 1'b0;
    set_in(4'h0, 0, 0, 0, 0);
    checks++;
    if (o_valid !== 1'b0 || o_last !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: oValid/oLast/oBusy=%b%b%b required 000", name, o_valid, o_last, o_busy);
    end
  endtask

  // Fills all four channels in lockstep, then confirms the one-cycle entry latency.
  task automatic fill_lockstep(input bit rnd);
    logic [31:0] v [4];
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check_no_valid("fill_early_valid");
      for (int c = 0; c < 4; c++) begin
        v[c] = rnd ? $urandom : 32'(c * 1000 + i);
        note_write(c, v[c]);
      end
      set_in(4'hF, v[0], v[1], v[2], v[3]);
    end
    @(negedge clk);
    set_in(4'h0, 0, 0, 0, 0);
    check_no_valid("entry_latency");
    build_sb();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rsn = 1'b0;
    set_in(4'($urandom), $urandom, $urandom, $urandom, $urandom);
    ready = 1'($urandom);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({o_valid, o_data, o_chan, o_idx, o_last, o_busy, o_ovf} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: v=%b d=%h c=%0d i=%0d l=%b b=%b o=%b required all 0",
                 o_valid, o_data, o_chan, o_idx, o_last, o_busy, o_ovf);
      end
      if (k < 2) set_in(4'($urandom), $urandom, $urandom, $urandom, $urandom);
    end
    rsn = 1'b1;
    ready = 1'b0;
    set_in(4'h0, 0, 0, 0, 0);
  endtask

  task automatic test_lockstep();
    fill_lockstep(1'b0);
    drain(100, 4 * N, -1);
    check_idle("lockstep_after_frame");
  endtask

  task automatic test_staggered();
    int          n3 = 0;
    logic [3:0]  v;
    logic [31:0] x [4];
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge clk);
      check_no_valid("stagger_early_valid");
      v = 4'h0;
      for (int c = 0; c < 3; c++) begin
        x[c] = 32'(c * 1000 + i);
        if (i < N) begin
          v[c] = 1'b1;
          note_write(c, x[c]);
        end
      end
      x[3] = 32'(3000 + n3);
      if (i % 2 == 1) begin
        v[3] = 1'b1;
        note_write(3, x[3]);
        n3++;
      end
      set_in(v, x[0], x[1], x[2], x[3]);
    end
    @(negedge clk);
    set_in(4'h0, 0, 0, 0, 0);
    check_no_valid("stagger_entry_latency");
    build_sb();
    drain(100, 4 * N, -1);
    check_idle("stagger_after_frame");
  endtask

  task automatic test_backpressure();
    fill_lockstep(1'b1);
    drain(50, 4 * N, -1);
    check_idle("bp_after_frame");
  endtask

  task automatic test_overflow();
    logic [3:0]  v;
    logic [31:0] x [4];
    checks++;
    if (o_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clean: oOvf=%b required 0", o_ovf);
    end
    for (int i = 0; i <= N; i++) begin
      @(negedge clk);
      check_no_valid("ovf_early_valid");
      v = 4'h0;
      x[0] = 32'(i);
      if (i < N) begin
        v[0] = 1'b1;
        note_write(0, x[0]);
      end else begin
        v[0] = 1'b1;
        x[0] = 32'hDEAD;
      end
      for (int c = 1; c < 4; c++) begin
        x[c] = 32'(c * 1000 + i - 1);
        if (i >= 1) begin
          v[c] = 1'b1;
          note_write(c, x[c]);
        end
      end
      set_in(v, x[0], x[1], x[2], x[3]);
    end
    @(negedge clk);
    set_in(4'h0, 0, 0, 0, 0);
    check_no_valid("ovf_entry_latency");
    checks++;
    if (o_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_full_drop: oOvf=%b required 1", o_ovf);
    end
    build_sb();
    drain(100, 4 * N, 10);
    check_idle("ovf_after_frame");
    checks++;
    if (o_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: oOvf=%b required 1", o_ovf);
    end
  endtask

  task automatic test_reset_mid_drain();
    fill_lockstep(1'b1);
    drain(100, 100, -1);
    @(negedge clk);
    rsn = 1'b0;
    ready = 1'b0;
    @(negedge clk);
    rsn = 1'b1;
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_ovf !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: oValid=%b oBusy=%b oOvf=%b required 0 0 0", o_valid, o_busy, o_ovf);
    end
    sb.delete();
    fill_lockstep(1'b0);
    checks++;
    if (o_ovf !== 1'b0) begin
      errors++;
      $display("FAIL refill_ovf: oOvf=%b required 0", o_ovf);
    end
    drain(100, 4 * N, -1);
    check_idle("refill_after_frame");
  endtask

  initial begin
    rsn = 1'b0;
    ready = 1'b0;
    set_in(4'h0, 0, 0, 0, 0);
    test_reset();
    test_lockstep();
    test_staggered();
    test_backpressure();
    test_overflow();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
